data_memory: RTL and testbench
==============================

# data_memory

Parametrised data memory for the RISC-V core's load/store unit, replacing the fixed 256-word, zero-latency, word-only memory. Accepts one request at a time over a valid/ready handshake and performs byte, halfword or word loads/stores with sign/zero extension. Delivers the response after a configurable latency, with a response handshake. Misaligned, reserved-size and out-of-range accesses are flagged instead of silently aliasing.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; any value ≥ 1.
- `LATENCY`, 1: cycles from request acceptance to `resp_valid`; legal range 1..15.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `req_we` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address.
- `req_size` input 2: 00 byte, 01 halfword, 10 word, 11 reserved (= funct3[1:0]).
- `req_unsigned` input 1: load zero-extends when 1, sign-extends when 0 (= funct3[2]); ignored for stores.
- `req_wdata` input 32: store data, taken from the low bits (`[7:0]`, `[15:0]` or `[31:0]`).
- `resp_valid` output 1: response present.
- `resp_ready` input 1: consumer takes the response.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: access was misaligned, reserved-size or out-of-range.

## Operation
- FSM states are IDLE, BUSY and RESP. Reset enters IDLE.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, the request is accepted at that edge.
  - The next state is RESP if `LATENCY` = 1. Otherwise it is BUSY, with the counter loaded to `LATENCY`-2.
- BUSY:
  - `req_ready` = 0.
  - The counter decrements each cycle.
  - At 0, go to RESP.
- RESP:
  - `resp_valid` = 1 and `req_ready` = 0.
  - `resp_rdata` and `resp_err` are held stable.
  - On `resp_ready`, go to IDLE.
- Error detection, evaluated at acceptance:
  - `req_size` = 11.
  - Halfword with `req_addr[0]` = 1.
  - Word with `req_addr[1:0]` ≠ 0.
  - Word index `req_addr[31:2]` ≥ `DEPTH_WORDS`.
  - An erroring request takes the same latency, returns `resp_err` = 1 and `resp_rdata` = 0, and never writes memory.
- Store:
  - Committed to the array at the acceptance edge.
  - Only the addressed byte lanes change: byte lane = `addr[1:0]`, halfword lanes = `addr[1]`×2 +{0,1}.
  - Response has `resp_rdata` = 0 and `resp_err` = 0.
- Load:
  - The word is read at the acceptance edge and the lane is selected by `addr[1:0]`.
  - The result is extended per `req_unsigned` and captured into the response register.
  - A load accepted after a store sees the store's data.
- Memory contents are not reset. Their initial value is X unless loaded by the testbench.

## Timing
- Reset values:
  - `req_ready` = 0 while `rst_n` = 0, then 1 once in IDLE.
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0.
  - State = IDLE, counter = 0.
- Response timing: a request accepted at edge k gives `resp_valid` = 1 from edge k+`LATENCY` onward, until the edge where `resp_ready` = 1.
- Back-to-back requests:
  - If the response handshakes at edge m, `req_ready` = 1 after m, and the next acceptance is possible at edge m+1.
  - Maximum throughput is one request per `LATENCY`+1 cycles.
  - `resp_ready` held high from the start causes no lost response.
- `resp_ready` outside RESP is ignored.
- `req_valid` while `req_ready` = 0 is ignored; the requester holds its request.
- Reset mid-operation (BUSY or RESP):
  - The pending response is discarded and outputs return to their reset values immediately.
  - An already-accepted store stays committed.

## Configuration
- `DMEM_TRACE_EN` defined: on each accepted request, `$display` prints time, load/store, address, size, wdata (stores) and error flag. On each response handshake, it prints rdata.
- `DMEM_TRACE_EN` undefined: no display statements compiled; behaviour is otherwise identical.

## Test plan
- Word store/load, `LATENCY` = 1: store 0xDEADBEEF at 0x50, then load word at 0x50 → `resp_rdata` = 0xDEADBEEF, `resp_err` = 0, `resp_valid` exactly 1 cycle after acceptance.
- Sub-word extension: with word 0x80F0_7F01 at 0x10:
  - `lb` at 0x13 → 0xFFFFFF80; `lbu` at 0x13 → 0x00000080.
  - `lh` at 0x12 → 0xFFFF80F0; `lhu` at 0x10 → 0x00007F01.
- Byte-lane store: word 0xFFFFFFFF at 0x78.
  - `sb` 0x12345678 at 0x79 → word reads 0xFFFF78FF.
  - Then `sh` 0xABCD at 0x7A → word reads 0xABCD78FF.
- Errors: each of the following → `resp_err` = 1, `resp_rdata` = 0, target memory unchanged:
  - `lw` at 0x82.
  - `lh` at 0x81.
  - `req_size` = 11.
  - `sw` at word index `DEPTH_WORDS`.
- Latency/backpressure, `LATENCY` = 4:
  - Load accepted at edge k → `resp_valid` rises at k+4.
  - Hold `resp_ready` = 0 for 3 cycles → data stable and `req_ready` = 0 throughout.
  - Handshake → `req_ready` = 1 next cycle.
- Reset in BUSY: assert `rst_n` = 0 two cycles after accepting a store.
  - `resp_valid` = 0 immediately, state = IDLE after release.
  - A subsequent load returns the stored value.

Source files
------------

// File: rtl/data_memory.sv
// Load/store data memory with valid/ready request and response handshakes, byte/half/word
// access with sign/zero extension, and error flagging. Define DMEM_TRACE_EN to print accesses.
module data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          in_range;
    logic          misaligned;
    logic          err;
    logic [AW-1:0] idx;
    logic [31:0]   rword;
    logic [31:0]   load_val;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;

    always_comb begin
        accept     = req_valid && req_ready && (state == IDLE);
        in_range   = {2'b00, req_addr[31:2]} < 32'(DEPTH_WORDS);
        misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        err        = (req_size == 2'b11) || misaligned || !in_range;
        idx        = req_addr[AW+1:2];
        rword      = mem[idx];
        rbyte      = rword[{req_addr[1:0], 3'b000} +: 8];
        rhalf      = req_addr[1] ? rword[31:16] : rword[15:0];
        be         = 4'b1111;
        wlanes     = req_wdata;
        load_val   = rword;
        case (req_size)
            2'b00: begin
                be       = 4'b0001 << req_addr[1:0];
                wlanes   = {4{req_wdata[7:0]}};
                load_val = req_unsigned ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            2'b01: begin
                be       = req_addr[1] ? 4'b1100 : 4'b0011;
                wlanes   = {2{req_wdata[15:0]}};
                load_val = req_unsigned ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
            end
            default: ;
        endcase
    end

    // Array has no reset; a store commits at its acceptance edge regardless of later resets.
    always_ff @(posedge clk) begin
        if (accept && req_we && !err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready  <= 1'b0;
                        resp_rdata <= (err || req_we) ? '0 : load_val;
                        resp_err   <= err;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= BUSY;
                            cnt   <= 4'(LATENCY - 2);
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst_n && accept)
            $display("%0t dmem %s addr=%h size=%0d wdata=%h err=%0b", $time,
                     req_we ? "ST" : "LD", req_addr, req_size, req_wdata, err);
        if (rst_n && (state == RESP) && resp_ready)
            $display("%0t dmem resp rdata=%h", $time, resp_rdata);
    end
`endif

endmodule

// File: tb/tb_data_memory.sv
// Randomized and directed bench for data_memory: two instances (LATENCY 1 and 4) checked every
// cycle against a byte-array reference model, plus literal expectations from the test plan.
module tb_data_memory;

    localparam int LAT0 = 1;
    localparam int LAT1 = 4;
    localparam int DEP0 = 64;
    localparam int DEP1 = 40;

    logic        clk;
    logic        rst_n        [2];
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [31:0] req_addr     [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_wdata    [2];
    logic        resp_valid   [2];
    logic        resp_ready   [2];
    logic [31:0] resp_rdata   [2];
    logic        resp_err     [2];

    int errors = 0;
    int checks = 0;

    logic [7:0]  mm     [2][256];
    bit          pend   [2] = '{0, 0};
    bit          fresh  [2] = '{1, 1};
    int          age    [2] = '{0, 0};
    logic [31:0] exp_rd [2];
    logic        exp_er [2];

    data_memory #(.DEPTH_WORDS(DEP0), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
        .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

    data_memory #(.DEPTH_WORDS(DEP1), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
        .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int dep_of(input int d);
        return (d == 0) ? DEP0 : DEP1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: memory as a flat byte array; response computed from the access rules.
    function automatic void model_access(input int d, input logic we, input logic [31:0] a,
                                         input logic [1:0] sz, input logic u,
                                         input logic [31:0] wd);
        int nb;
        logic e;
        logic [31:0] val;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e = (sz == 2'd3) || ((a % nb) != 0) || ((a >> 2) >= 32'(dep_of(d)));
        exp_rd[d] = '0;
        exp_er[d] = e;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mm[d][a + i] = wd[8*i +: 8];
            end else begin
                val = '0;
                for (int i = 0; i < nb; i++) val = val | (32'(mm[d][a + i]) << (8 * i));
                if (!u && nb < 4 && val[8*nb-1]) val = val | (~32'h0 << (8 * nb));
                exp_rd[d] = val;
            end
        end
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n[d]) begin
                pend[d]  = 0;
                fresh[d] = 1;
            end else if (fresh[d]) begin
                fresh[d] = 0;
            end else if (pend[d]) begin
                if (age[d] >= lat_of(d) - 1) begin
                    if (resp_ready[d]) pend[d] = 0;
                end else begin
                    age[d]++;
                end
            end else if (req_valid[d]) begin
                model_access(d, req_we[d], req_addr[d], req_size[d], req_unsigned[d], req_wdata[d]);
                pend[d] = 1;
                age[d]  = 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n[d]) begin
                chk($sformatf("rst_valid%0d", d), 32'(resp_valid[d]), 32'd0);
                chk($sformatf("rst_ready%0d", d), 32'(req_ready[d]), 32'd0);
                chk($sformatf("rst_rdata%0d", d), resp_rdata[d], 32'd0);
                chk($sformatf("rst_err%0d", d), 32'(resp_err[d]), 32'd0);
            end else begin
                logic ev;
                ev = pend[d] && (age[d] >= lat_of(d) - 1);
                chk($sformatf("resp_valid%0d", d), 32'(resp_valid[d]), 32'(ev));
                if (!fresh[d]) chk($sformatf("req_ready%0d", d), 32'(req_ready[d]), 32'(!pend[d]));
                if (ev) begin
                    chk($sformatf("resp_rdata%0d", d), resp_rdata[d], exp_rd[d]);
                    chk($sformatf("resp_err%0d", d), 32'(resp_err[d]), 32'(exp_er[d]));
                end
            end
        end
    end

    task automatic issue(input int d, input logic we, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [31:0] wd, input logic early);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) chk("ready_timeout", 32'd0, 32'd1);
        req_we[d]       = we;
        req_addr[d]     = a;
        req_size[d]     = sz;
        req_unsigned[d] = u;
        req_wdata[d]    = wd;
        req_valid[d]    = 1'b1;
        resp_ready[d]   = early;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
    endtask

    task automatic finish(input int d, input int hold, output logic [31:0] rd, output logic er,
                          output int lat);
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (resp_valid[d]) break;
            lat++;
        end
        if (!resp_valid[d]) begin
            chk("resp_timeout", 32'd0, 32'd1);
            resp_ready[d] = 1'b0;
            rd = '0;
            er = 1'b0;
            return;
        end
        repeat (hold) @(negedge clk);
        rd = resp_rdata[d];
        er = resp_err[d];
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1 resp_ready[d] = 1'b0;
    endtask

    task automatic op(input int d, input logic we, input logic [31:0] a, input logic [1:0] sz,
                      input logic u, input logic [31:0] wd, input int hold, input logic early,
                      output logic [31:0] rd, output logic er, output int lat);
        issue(d, we, a, sz, u, wd, early);
        finish(d, hold, rd, er, lat);
    endtask

    task automatic st(input int d, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] rd;
        logic er;
        int lat;
        op(d, 1'b1, a, sz, 1'b0, wd, 0, 1'b0, rd, er, lat);
    endtask

    task automatic ld_chk(input int d, input string nm, input logic [31:0] a, input logic [1:0] sz,
                          input logic u, input logic [31:0] exp);
        logic [31:0] rd;
        logic er;
        int lat;
        op(d, 1'b0, a, sz, u, 32'h0, 0, 1'b0, rd, er, lat);
        chk(nm, rd, exp);
        chk({nm, "_err"}, 32'(er), 32'd0);
    endtask

    task automatic err_chk(input int d, input string nm, input logic we, input logic [31:0] a,
                           input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] rd;
        logic er;
        int lat;
        op(d, we, a, sz, 1'b0, wd, 0, 1'b0, rd, er, lat);
        chk({nm, "_err"}, 32'(er), 32'd1);
        chk({nm, "_rdata"}, rd, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic er;
        int lat;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_size[d] = '0; req_unsigned[d] = 1'b0; req_wdata[d] = '0; resp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset0", 32'(req_ready[0]), 32'd1);
        chk("ready_after_reset1", 32'(req_ready[1]), 32'd1);

        // LATENCY = 1 instance
        st(0, 32'h50, 2'd2, 32'hDEADBEEF);
        op(0, 1'b0, 32'h50, 2'd2, 1'b0, 32'h0, 0, 1'b0, rd, er, lat);
        chk("lw_50", rd, 32'hDEADBEEF);
        chk("lw_50_err", 32'(er), 32'd0);
        chk("lat1", 32'(lat), 32'd0);

        st(0, 32'h10, 2'd2, 32'h80F07F01);
        ld_chk(0, "lb_13", 32'h13, 2'd0, 1'b0, 32'hFFFFFF80);
        ld_chk(0, "lbu_13", 32'h13, 2'd0, 1'b1, 32'h00000080);
        ld_chk(0, "lh_12", 32'h12, 2'd1, 1'b0, 32'hFFFF80F0);
        ld_chk(0, "lhu_10", 32'h10, 2'd1, 1'b1, 32'h00007F01);

        st(0, 32'h78, 2'd2, 32'hFFFFFFFF);
        st(0, 32'h79, 2'd0, 32'h12345678);
        ld_chk(0, "sb_79", 32'h78, 2'd2, 1'b0, 32'hFFFF78FF);
        st(0, 32'h7A, 2'd1, 32'h0000ABCD);
        ld_chk(0, "sh_7a", 32'h78, 2'd2, 1'b0, 32'hABCD78FF);

        st(0, 32'h80, 2'd2, 32'h11111111);
        st(0, 32'h00, 2'd2, 32'h0BADF00D);
        err_chk(0, "lw_82", 1'b0, 32'h82, 2'd2, 32'h0);
        err_chk(0, "lh_81", 1'b0, 32'h81, 2'd1, 32'h0);
        err_chk(0, "ld_sz3", 1'b0, 32'h80, 2'd3, 32'h0);
        err_chk(0, "st_sz3", 1'b1, 32'h80, 2'd3, 32'h0);
        err_chk(0, "sw_82", 1'b1, 32'h82, 2'd2, 32'hAAAAAAAA);
        err_chk(0, "sw_oor", 1'b1, 32'(DEP0 * 4), 2'd2, 32'h55555555);
        ld_chk(0, "after_err_80", 32'h80, 2'd2, 1'b0, 32'h11111111);
        ld_chk(0, "after_oor_00", 32'h00, 2'd2, 1'b0, 32'h0BADF00D);

        for (int i = 0; i < 4; i++) begin
            op(0, 1'b0, 32'h50, 2'd2, 1'b0, 32'h0, 0, 1'b1, rd, er, lat);
            chk("early_ready", rd, 32'hDEADBEEF);
        end

        // LATENCY = 4 instance
        st(1, 32'h20, 2'd2, 32'h00C0FFEE);
        op(1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 3, 1'b0, rd, er, lat);
        chk("lat4", 32'(lat), 32'd3);
        chk("bp_rdata", rd, 32'h00C0FFEE);
        @(negedge clk);
        chk("ready_after_hs", 32'(req_ready[1]), 32'd1);
        err_chk(1, "sw_oor1", 1'b1, 32'(DEP1 * 4), 2'd2, 32'h0);
        err_chk(1, "lw_oor1", 1'b0, 32'h8000_0000, 2'd2, 32'h0);

        issue(1, 1'b1, 32'h24, 2'd2, 1'b0, 32'h5A5A1234, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n[1] = 1'b0;
        #1 chk("rst_busy_valid", 32'(resp_valid[1]), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n[1] = 1'b1;
        ld_chk(1, "after_rst_24", 32'h24, 2'd2, 1'b0, 32'h5A5A1234);

        issue(1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 1'b0);
        repeat (6) @(negedge clk);
        chk("resp_pending", 32'(resp_valid[1]), 32'd1);
        #1 rst_n[1] = 1'b0;
        #1 chk("rst_resp_valid", 32'(resp_valid[1]), 32'd0);
        chk("rst_resp_rdata", resp_rdata[1], 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n[1] = 1'b1;

        // Randomized traffic checked by the per-cycle model comparison
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) st(d, 32'(w * 4), 2'd2, $urandom);
            for (int n = 0; n < 150; n++) begin
                logic [31:0] a;
                int r, hold;
                r = $urandom_range(0, 9);
                if (r < 8) a = 32'($urandom_range(0, 63));
                else if (r == 8) a = 32'(dep_of(d) * 4) + 32'($urandom_range(0, 7));
                else a = {1'b1, 31'($urandom)};
                hold = $urandom_range(0, 2);
                op(d, 1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, hold,
                   (hold == 0) ? 1'($urandom) : 1'b0, rd, er, lat);
            end
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
